// File: rtl/dbg_addr_seq.sv
// dbg_addr_seq: address sweep generator feeding the priority-case address
// decoder. It walks dbg_addr from 0 up to LAST_ADDR in STRIDE steps, one
// address per accepted beat, and counts completed sweeps (saturating).
//
// Optional build macro: DBG_ADDR_SEQ_WRAP_EN
//   defined   -> continuous sweep: after the last beat the address wraps to
//                0, out_valid stays high, done pulses and sweep_cnt counts
//                on every wrap; the sweep runs until stop or rst.
//   undefined -> a completed sweep ends in DONE with a one-cycle done pulse.
//
// Handshake (out_valid/out_ready): a beat is accepted at a rising clk edge
// where out_valid && out_ready. Once out_valid is high, dbg_addr is held
// stable and out_valid stays high until that beat is accepted; only rst may
// drop an unaccepted beat. out_ready may be high when out_valid is low and
// has no effect then.
//
// dbg_state exposes the FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3).

module dbg_addr_seq #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 3,
    parameter logic [ADDR_W-1:0] STRIDE = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sweep_cnt,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // One extra bit so a carry out of the address counts as "past the end".
    localparam logic [ADDR_W:0] LAST_EXT   = {1'b0, LAST_ADDR};
    localparam logic [ADDR_W:0] STRIDE_EXT = {1'b0, STRIDE};

    logic [1:0]        state;
    logic              accept;
    logic [ADDR_W:0]   next_addr;
    logic              is_last;
    logic [CNT_W-1:0]  cnt_next;

    // Beat acceptance and the address that follows it.
    always_comb begin
        accept    = out_valid && out_ready;
        next_addr = {1'b0, dbg_addr} + STRIDE_EXT;
        is_last   = (next_addr > LAST_EXT);
        cnt_next  = (sweep_cnt == {CNT_W{1'b1}}) ? sweep_cnt
                                                 : sweep_cnt + CNT_W'(1);
    end

    // Sweep FSM together with all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            dbg_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sweep_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    // stop beats start; otherwise stay where we are.
                    if (start && !stop) begin
                        state     <= ST_RUN;
                        out_valid <= 1'b1;
                        dbg_addr  <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        if (accept) begin
                            // Abort wins even on the last beat: no done, no count.
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            dbg_addr  <= '0;
                            busy      <= 1'b0;
                        end else begin
                            // Beat still pending: hold it until the decoder takes it.
                            state <= ST_DRAIN;
                        end
                    end else if (accept) begin
                        if (is_last) begin
                            done      <= 1'b1;
                            sweep_cnt <= cnt_next;
                            dbg_addr  <= '0;
`ifdef DBG_ADDR_SEQ_WRAP_EN
                            // Continuous sweep: restart at 0 without a gap.
                            out_valid <= 1'b1;
`else
                            state     <= ST_DONE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
`endif
                        end else begin
                            dbg_addr <= next_addr[ADDR_W-1:0];
                        end
                    end
                end
                ST_DRAIN: begin
                    // stop is irrelevant here; only acceptance ends the drain.
                    if (accept) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        dbg_addr  <= '0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    dbg_addr  <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Expose the FSM state for checkers.
    always_comb begin
        dbg_state = state;
    end

endmodule
